alu_cmd_issuer: RTL and testbench

//   Sequential front end that feeds the combinational 10-op ALU and collects its results.

---
 rtl/alu_cmd_issuer.sv | 183 ++++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Command front end for the 10-op ALU: queues tagged commands, drives the ALU from registers,
// samples the result after ALU_LAT cycles and returns it over a valid/ready response stream.
module alu_cmd_issuer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHW     = 5,
    parameter int unsigned TAGW    = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [SHW-1:0]   cmd_shift,
    input  logic [TAGW-1:0]  cmd_tag,
    output logic [3:0]       opcode,
    output logic [WIDTH-1:0] input1,
    output logic [WIDTH-1:0] input2,
    output logic [SHW-1:0]   shiftValue,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic [TAGW-1:0]  rsp_tag,
    output logic             rsp_illegal,
    output logic             busy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [SHW-1:0]   sh;
        logic [TAGW-1:0]  tag;
    } entry_t;

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    entry_t          mem_q [DEPTH];
    logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
    logic            full, empty, push, pop;
    entry_t          head;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [TAGW-1:0] cur_tag_q;
    logic [3:0]      opcode_q;
    logic [WIDTH-1:0] input1_q, input2_q;
    logic [SHW-1:0]  shift_q;
    logic            rsp_valid_q, rsp_carry_q, rsp_illegal_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic [TAGW-1:0] rsp_tag_q;
    logic            is_cmp, cmp_bit;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign head  = mem_q[rd_ptr_q[PtrW-1:0]];

    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == StIdle) && !empty && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[PtrW-1:0]] <= '{op: cmd_opcode, a: cmd_a, b: cmd_b,
                                                sh: cmd_shift, tag: cmd_tag};
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // The ALU leaves compare results unassigned, so they are evaluated here.
    always_comb begin
        is_cmp  = 1'b0;
        cmp_bit = 1'b0;
        unique case (opcode_q)
            4'd0: begin
                is_cmp  = 1'b1;
                cmp_bit = $signed(input1_q) >= $signed(input2_q);
            end
            4'd2: begin
                is_cmp  = 1'b1;
                cmp_bit = $signed(input1_q) > $signed(input2_q);
            end
            4'd3: begin
                is_cmp  = 1'b1;
                cmp_bit = $signed(input1_q) < $signed(input2_q);
            end
            4'd6: begin
                is_cmp  = 1'b1;
                cmp_bit = input1_q < input2_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            cur_tag_q     <= '0;
            opcode_q      <= '0;
            input1_q      <= '0;
            input2_q      <= '0;
            shift_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_carry_q   <= 1'b0;
            rsp_tag_q     <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        if (head.op < 4'd10) begin
                            opcode_q  <= head.op;
                            input1_q  <= head.a;
                            input2_q  <= head.b;
                            shift_q   <= head.sh;
                            cur_tag_q <= head.tag;
                            cnt_q     <= CntW'(ALU_LAT);
                            state_q   <= StWait;
                        end else begin
                            rsp_result_q  <= '0;
                            rsp_carry_q   <= 1'b0;
                            rsp_illegal_q <= 1'b1;
                            rsp_tag_q     <= head.tag;
                            rsp_valid_q   <= 1'b1;
                            state_q       <= StHold;
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        rsp_result_q  <= is_cmp ? WIDTH'(cmp_bit) : alu_result;
                        rsp_carry_q   <= is_cmp ? 1'b0 : alu_carry;
                        rsp_tag_q     <= cur_tag_q;
                        rsp_illegal_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= StHold;
                    end
                end
                StHold: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign opcode      = opcode_q;
    assign input1      = input1_q;
    assign input2      = input2_q;
    assign shiftValue  = shift_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_carry   = rsp_carry_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_illegal = rsp_illegal_q;
    assign busy        = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: one instance at ALU_LAT=1, one at ALU_LAT=3,
// each fed by a behavioural ALU model.
module tb_alu_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_valid3 = 1'b0;
    logic [3:0]  cmd_opcode = '0;
    logic [31:0] cmd_a = '0, cmd_b = '0;
    logic [4:0]  cmd_shift = '0;
    logic [3:0]  cmd_tag = '0;
    logic        rsp_ready = 1'b0, rsp_ready3 = 1'b1;

    logic        cmd_ready, cmd_ready3;
    logic [3:0]  opcode, opcode3;
    logic [31:0] input1, input2, input1_3, input2_3;
    logic [4:0]  shiftValue, shiftValue3;
    logic [31:0] alu_result, alu_result3;
    logic        alu_carry, alu_carry3;
    logic        rsp_valid, rsp_valid3;
    logic [31:0] rsp_result, rsp_result3;
    logic        rsp_carry, rsp_carry3;
    logic [3:0]  rsp_tag, rsp_tag3;
    logic        rsp_illegal, rsp_illegal3;
    logic        busy, busy3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural ALU; compares return junk so the DUT must compute them itself.
    function automatic logic [32:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] sh);
        logic [63:0] dbl;
        dbl = {a, a} >> sh;
        case (op)
            4'd1:    return {1'b0, ($signed(a) > $signed(b)) ? a : b};
            4'd4:    return {1'b0, ~(a & b)};
            4'd5:    return {1'b1, dbl[31:0]};
            4'd7:    return {1'b0, 32'($signed(a) >>> sh)};
            4'd8:    return {1'b0, ($signed(a) < $signed(b)) ? a : b};
            4'd9:    return {1'b1, a | b};
            default: return {1'b1, 32'hDEAD_BEEF};
        endcase
    endfunction

    assign {alu_carry, alu_result}   = alu_model(opcode, input1, input2, shiftValue);
    assign {alu_carry3, alu_result3} = alu_model(opcode3, input1_3, input2_3, shiftValue3);

    alu_cmd_issuer #(.WIDTH(32), .SHW(5), .TAGW(4), .DEPTH(4), .ALU_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift),
        .cmd_tag(cmd_tag), .opcode(opcode), .input1(input1), .input2(input2),
        .shiftValue(shiftValue), .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal), .busy(busy)
    );

    alu_cmd_issuer #(.WIDTH(32), .SHW(5), .TAGW(4), .DEPTH(4), .ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift),
        .cmd_tag(cmd_tag), .opcode(opcode3), .input1(input1_3), .input2(input2_3),
        .shiftValue(shiftValue3), .alu_result(alu_result3), .alu_carry(alu_carry3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
        .rsp_carry(rsp_carry3), .rsp_tag(rsp_tag3), .rsp_illegal(rsp_illegal3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [3:0] tg);
        int n;
        cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shift = sh; cmd_tag = tg;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        if (!cmd_ready) chk("push_timeout", 64'd0, 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        if (!rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("ack_valid_low", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [31:0] ea;

        // Reset state
        tick(); tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_opcode", 64'(opcode), 64'd0);
        chk("rst_input1", 64'(input1), 64'd0);
        chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        rst = 1'b0;
        tick();
        chk("cmd_ready_out_of_rst", 64'(cmd_ready), 64'd1);

        // 1: OR with exact latency
        push(4'd9, 32'h0000_F0F0, 32'h0F0F_0000, 5'd0, 4'd3);
        chk("t1_valid_at_n", 64'(rsp_valid), 64'd0);
        tick();
        chk("t1_valid_at_n1", 64'(rsp_valid), 64'd0);
        chk("t1_drive_op", 64'(opcode), 64'd9);
        chk("t1_drive_a", 64'(input1), 64'h0000_F0F0);
        chk("t1_busy", 64'(busy), 64'd1);
        tick();
        chk("t1_valid_at_n2", 64'(rsp_valid), 64'd1);
        chk("t1_result", 64'(rsp_result), 64'h0F0F_F0F0);
        chk("t1_carry", 64'(rsp_carry), 64'd1);
        chk("t1_tag", 64'(rsp_tag), 64'd3);
        chk("t1_illegal", 64'(rsp_illegal), 64'd0);
        ack();
        chk("t1_idle", 64'(busy), 64'd0);

        // 2: local compares, ALU junk ignored
        push(4'd3, 32'hFFFF_FFFF, 32'd1, 5'd0, 4'd4);
        wait_rsp();
        chk("t2_slt", 64'(rsp_result), 64'd1);
        chk("t2_slt_carry", 64'(rsp_carry), 64'd0);
        ack();
        push(4'd6, 32'hFFFF_FFFF, 32'd1, 5'd0, 4'd5);
        wait_rsp();
        chk("t2_sltu", 64'(rsp_result), 64'd0);
        chk("t2_sltu_carry", 64'(rsp_carry), 64'd0);
        ack();
        push(4'd0, 32'd5, 32'd5, 5'd0, 4'd6);
        wait_rsp();
        chk("t2_sge_eq", 64'(rsp_result), 64'd1);
        ack();
        push(4'd2, 32'd5, 32'd5, 5'd0, 4'd6);
        wait_rsp();
        chk("t2_sgt_eq", 64'(rsp_result), 64'd0);
        ack();
        push(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 4'd2);
        wait_rsp();
        chk("t2_nand", 64'(rsp_result), 64'h0FFF_0FFF);
        chk("t2_nand_carry", 64'(rsp_carry), 64'd0);
        ack();

        // 3: illegal opcode
        push(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 4'd7);
        chk("t3_valid_at_n", 64'(rsp_valid), 64'd0);
        tick();
        chk("t3_valid_at_n1", 64'(rsp_valid), 64'd1);
        chk("t3_illegal", 64'(rsp_illegal), 64'd1);
        chk("t3_result", 64'(rsp_result), 64'd0);
        chk("t3_carry", 64'(rsp_carry), 64'd0);
        chk("t3_tag", 64'(rsp_tag), 64'd7);
        chk("t3_drive_op_kept", 64'(opcode), 64'd4);
        chk("t3_drive_a_kept", 64'(input1), 64'hF0F0_F0F0);
        ack();

        // 4: backpressure, FIFO full, in-order return
        for (int k = 1; k <= 5; k++) push(4'd9, 32'(k) << 8, 32'(k), 5'd0, 4'(k));
        chk("t4_full_ready", 64'(cmd_ready), 64'd0);
        tick(); tick(); tick();
        chk("t4_still_full", 64'(cmd_ready), 64'd0);
        chk("t4_hold_valid", 64'(rsp_valid), 64'd1);
        chk("t4_hold_tag", 64'(rsp_tag), 64'd1);
        chk("t4_hold_result", 64'(rsp_result), 64'h0000_0101);
        rsp_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_rsp();
            ea = (32'(k) << 8) | 32'(k);
            chk("t4_order_tag", 64'(rsp_tag), 64'(k));
            chk("t4_order_result", 64'(rsp_result), 64'(ea));
            tick();
        end
        rsp_ready = 1'b0;
        chk("t4_drained", 64'(busy), 64'd0);

        // 5: reset while waiting with two queued
        push(4'd9, 32'd1, 32'd2, 5'd0, 4'd8);
        push(4'd4, 32'hAAAA_0000, 32'h5555_FFFF, 5'd3, 4'd9);
        push(4'd9, 32'd3, 32'd4, 5'd0, 4'd10);
        push(4'd9, 32'd5, 32'd6, 5'd0, 4'd11);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        chk("t5_pre_busy", 64'(busy), 64'd1);
        chk("t5_pre_drive_op", 64'(opcode), 64'd4);
        chk("t5_pre_valid", 64'(rsp_valid), 64'd0);
        rst = 1'b1;
        tick();
        chk("t5_valid", 64'(rsp_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_drives", {opcode, input1, input2[27:0]}, 64'd0);
        chk("t5_shift", 64'(shiftValue), 64'd0);
        chk("t5_ready_in_rst", 64'(cmd_ready), 64'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid) cnt++;
        end
        rsp_ready = 1'b0;
        chk("t5_no_stale", 64'(cnt), 64'd0);
        chk("t5_busy_after", 64'(busy), 64'd0);

        // 6: ROR on the ALU_LAT=3 instance
        cmd_opcode = 4'd5; cmd_a = 32'h8000_0001; cmd_b = 32'd0; cmd_shift = 5'd1;
        cmd_tag = 4'd13;
        cmd_valid3 = 1'b1;
        chk("t6_ready", 64'(cmd_ready3), 64'd1);
        tick();
        cmd_valid3 = 1'b0;
        tick();
        chk("t6_drive_op", 64'(opcode3), 64'd5);
        chk("t6_drive_sh", 64'(shiftValue3), 64'd1);
        chk("t6_valid_d1", 64'(rsp_valid3), 64'd0);
        tick(); tick();
        chk("t6_valid_d3m", 64'(rsp_valid3), 64'd0);
        tick();
        chk("t6_valid_d3", 64'(rsp_valid3), 64'd1);
        chk("t6_result", 64'(rsp_result3), 64'hC000_0000);
        chk("t6_carry", 64'(rsp_carry3), 64'd1);
        chk("t6_tag", 64'(rsp_tag3), 64'd13);
        tick();
        chk("t6_acked", 64'(rsp_valid3), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
